ycc_to_rgb_upsampler: RTL

//  Decode side of the 4:2:0 colour path. Accepts one 2x2 block per handshake: 4 luma bytes plus one shared Cb/Cr pair.

---
 rtl/ycc_to_rgb_upsampler.sv | 113 +++++++++++
 1 files changed

// File: rtl/ycc_to_rgb_upsampler.sv
// 4:2:0 block to RGB pixel stream: one 2x2 block in, 4 RGB pixels out (UL,UR,DL,DR); pixel 0 one cycle after accept.
// Output held stable under out_ready backpressure; next block accepted only on the last pixel's handshake.
module ycc_to_rgb_upsampler #(
  parameter int ROUND_EN  = 1,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_y,
  input  logic [15:0]          in_cbcr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [23:0]          out_rgb,
  output logic [1:0]           out_idx,
  output logic                 out_last,
  output logic [BLK_CNT_W-1:0] blk_count
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EMIT = 1'b1;
  localparam logic signed [19:0] RND = (ROUND_EN != 0) ? 20'sd64 : 20'sd0;

  logic                 state_q, state_d;
  logic [23:0]          y_q, y_d;       // luma of pixels 1..3; pixel 0 is converted at accept
  logic [15:0]          cbcr_q, cbcr_d;
  logic [1:0]           idx_q, idx_d;
  logic [23:0]          rgb_q, rgb_d;
  logic [BLK_CNT_W-1:0] blk_q, blk_d;
  logic [7:0]           y_next;
  logic                 accept, fire;

  function automatic logic [7:0] clamp8(input logic signed [19:0] x);
    if (x < 20'sd0)        return 8'd0;
    else if (x > 20'sd255) return 8'd255;
    else                   return x[7:0];
  endfunction

  function automatic logic [23:0] conv(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    logic signed [19:0] d, u, v, r, g, b;
    d = $signed({12'd0, y})  - 20'sd16;
    u = $signed({12'd0, cb}) - 20'sd128;
    v = $signed({12'd0, cr}) - 20'sd128;
    r = (20'sd149 * d + 20'sd204 * v + RND) >>> 7;
    g = (20'sd149 * d - 20'sd50 * u - 20'sd104 * v + RND) >>> 7;
    b = (20'sd149 * d + 20'sd258 * u + RND) >>> 7;
    return {clamp8(b), clamp8(g), clamp8(r)};
  endfunction

  assign out_valid = (state_q == ST_EMIT);
  assign out_rgb   = rgb_q;
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == 2'd3);
  assign blk_count = blk_q;
  // Combinational out_ready path lets the next block land with no bubble.
  assign in_ready  = !out_valid || (out_ready && (idx_q == 2'd3));
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  always_comb begin
    case (idx_q)
      2'd0:    y_next = y_q[7:0];
      2'd1:    y_next = y_q[15:8];
      default: y_next = y_q[23:16];
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cbcr_d  = cbcr_q;
    idx_d   = idx_q;
    rgb_d   = rgb_q;
    blk_d   = blk_q;
    if (fire) begin
      if (idx_q == 2'd3) begin
        blk_d   = blk_q + {{(BLK_CNT_W-1){1'b0}}, 1'b1};
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
        rgb_d = conv(y_next, cbcr_q[7:0], cbcr_q[15:8]);
      end
    end
    if (accept) begin
      y_d     = in_y[31:8];
      cbcr_d  = in_cbcr;
      state_d = ST_EMIT;
      idx_d   = 2'd0;
      rgb_d   = conv(in_y[7:0], in_cbcr[7:0], in_cbcr[15:8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      cbcr_q  <= '0;
      idx_q   <= '0;
      rgb_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cbcr_q  <= cbcr_d;
      idx_q   <= idx_d;
      rgb_q   <= rgb_d;
      blk_q   <= blk_d;
    end
  end

endmodule
